// File: rtl/flag_pkg.sv
// Shared definitions for the 8085 PSW flag unit: PSW bit positions,
// update-mask positions, ccc condition codes, cy_op encodings and the
// fixed-bit handling of the PSW image.
package flag_pkg;

  localparam int PSW_W = 8;

  // Flag positions inside the PSW byte {S,Z,0,AC,0,P,1,CY}
  localparam int BIT_CY = 0;
  localparam int BIT_P  = 2;
  localparam int BIT_AC = 4;
  localparam int BIT_Z  = 6;
  localparam int BIT_S  = 7;

  // Flag positions inside upd_mask {S,Z,AC,P,CY}
  localparam int MSK_CY = 0;
  localparam int MSK_P  = 1;
  localparam int MSK_AC = 2;
  localparam int MSK_Z  = 3;
  localparam int MSK_S  = 4;

  // Writable PSW bits (7,6,4,2,0) and the constant-one bit (1)
  localparam logic [7:0] PSW_WR_MASK    = 8'hD5;
  localparam logic [7:0] PSW_FIXED_ONES = 8'h02;

  // ccc branch condition codes
  typedef enum logic [2:0] {
    CC_NZ = 3'd0,
    CC_Z  = 3'd1,
    CC_NC = 3'd2,
    CC_C  = 3'd3,
    CC_PO = 3'd4,
    CC_PE = 3'd5,
    CC_P  = 3'd6,
    CC_M  = 3'd7
  } ccc_e;

  // Carry-flag operations (STC / CMC)
  typedef enum logic [1:0] {
    CY_NONE = 2'b00,
    CY_STC  = 2'b01,
    CY_CMC  = 2'b10,
    CY_NOP  = 2'b11
  } cy_op_e;

  // Force the fixed PSW bits: 5 and 3 to 0, 1 to 1
  function automatic logic [7:0] psw_fix(input logic [7:0] v);
    return (v & PSW_WR_MASK) | PSW_FIXED_ONES;
  endfunction

endpackage

// File: rtl/flag_save_stack.sv
// LIFO of PSW images used on interrupt entry/exit. Handles push, pop,
// same-edge swap, occupancy and a sticky overflow/underflow error.
// State changes on the falling clock edge like the rest of the flag unit.
module flag_save_stack #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [7:0]       din,
  output logic [7:0]       top,
  output logic             pop_ok,
  output logic [PTR_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_count;
  logic             r_err;

  logic             w_empty;
  logic             w_full;
  logic             w_swap;
  logic             w_pop_only;
  logic             w_push_only;
  logic             w_ovf;
  logic             w_unf;
  logic             w_wr_en;
  logic [IDX_W-1:0] w_top_idx;
  logic [IDX_W-1:0] w_wr_idx;
  logic [PTR_W-1:0] w_count_nxt;

  assign w_empty   = (r_count == {PTR_W{1'b0}});
  assign w_full    = (r_count == PTR_W'(DEPTH));
  assign w_top_idx = IDX_W'(r_count - PTR_W'(1));

  // A push and a pop on a non-empty stack exchange the top entry instead
  assign w_swap      = push & pop & ~w_empty;
  assign w_pop_only  = pop & ~push & ~w_empty;
  assign w_push_only = push & ~w_full & ~(pop & ~w_empty);
  assign w_ovf       = push & ~pop & w_full;
  assign w_unf       = pop & w_empty;
  assign w_wr_en     = w_swap | w_push_only;

  // Occupancy next-state and the memory slot written this edge
  always_comb begin
    w_count_nxt = r_count;
    w_wr_idx    = IDX_W'(r_count);
    if (w_swap) begin
      w_count_nxt = r_count;
      w_wr_idx    = w_top_idx;
    end else if (w_push_only) begin
      w_count_nxt = r_count + PTR_W'(1);
      w_wr_idx    = IDX_W'(r_count);
    end else if (w_pop_only) begin
      w_count_nxt = r_count - PTR_W'(1);
      w_wr_idx    = IDX_W'(r_count);
    end else begin
      w_count_nxt = r_count;
      w_wr_idx    = IDX_W'(r_count);
    end
  end

  // Occupancy counter and sticky error flag
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= {PTR_W{1'b0}};
      r_err   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_err   <= r_err | w_ovf | w_unf;
    end
  end

  // Entry storage; contents are meaningless until written
  always_ff @(negedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= din;
    end
  end

  assign top    = r_mem[w_top_idx];
  assign pop_ok = pop & ~w_empty;
  assign count  = r_count;
  assign full   = w_full;
  assign empty  = w_empty;
  assign err    = r_err;

endmodule

// File: rtl/psw_flag_unit.sv
// 8085 program-status-word flag unit: PSW register with masked ALU update,
// full load, STC/CMC, interrupt save stack and ccc condition evaluation.
// All state updates occur on the falling edge of clk.
module psw_flag_unit
  import flag_pkg::*;
#(
  parameter int         STACK_DEPTH = 4,
  parameter logic [7:0] RESET_PSW   = 8'h02,
  parameter int         PTR_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             upd_en,
  input  logic [4:0]       upd_mask,
  input  logic             is_sign,
  input  logic             is_zero,
  input  logic             is_aux,
  input  logic             is_parity,
  input  logic             is_carry,
  input  logic             psw_load,
  input  logic [7:0]       psw_in,
  input  logic [1:0]       cy_op,
  input  logic             save_req,
  input  logic             restore_req,
  input  logic [2:0]       cond_sel,
  output logic [7:0]       psw_out,
  output logic             flg_sign,
  output logic             flg_zero,
  output logic             flg_aux,
  output logic             flg_parity,
  output logic             flg_carry,
  output logic             cond_met,
  output logic [PTR_W-1:0] stk_count,
  output logic             stk_full,
  output logic             stk_empty,
  output logic             stk_err
);

  logic [7:0] r_psw;
  logic [7:0] w_upd_psw;
  logic [7:0] w_alu_psw;
  logic [7:0] w_psw_nxt;
  logic [7:0] w_stk_top;
  logic       w_pop_ok;
  logic       w_cond;

  // The stack always receives the PSW as it stood before this edge
  flag_save_stack #(
    .DEPTH (STACK_DEPTH),
    .PTR_W (PTR_W)
  ) u_stack (
    .clk    (clk),
    .reset  (reset),
    .push   (save_req),
    .pop    (restore_req),
    .din    (r_psw),
    .top    (w_stk_top),
    .pop_ok (w_pop_ok),
    .count  (stk_count),
    .full   (stk_full),
    .empty  (stk_empty),
    .err    (stk_err)
  );

  // Masked ALU flag update; unmasked flags keep their value
  always_comb begin
    w_upd_psw = r_psw;
    if (upd_en) begin
      if (upd_mask[MSK_S])  w_upd_psw[BIT_S]  = is_sign;   else w_upd_psw[BIT_S]  = r_psw[BIT_S];
      if (upd_mask[MSK_Z])  w_upd_psw[BIT_Z]  = is_zero;   else w_upd_psw[BIT_Z]  = r_psw[BIT_Z];
      if (upd_mask[MSK_AC]) w_upd_psw[BIT_AC] = is_aux;    else w_upd_psw[BIT_AC] = r_psw[BIT_AC];
      if (upd_mask[MSK_P])  w_upd_psw[BIT_P]  = is_parity; else w_upd_psw[BIT_P]  = r_psw[BIT_P];
      if (upd_mask[MSK_CY]) w_upd_psw[BIT_CY] = is_carry;  else w_upd_psw[BIT_CY] = r_psw[BIT_CY];
    end else begin
      w_upd_psw = r_psw;
    end
  end

  // STC/CMC override the carry after the masked update; CMC uses the old CY
  always_comb begin
    w_alu_psw = w_upd_psw;
    case (cy_op_e'(cy_op))
      CY_STC:  w_alu_psw[BIT_CY] = 1'b1;
      CY_CMC:  w_alu_psw[BIT_CY] = ~r_psw[BIT_CY];
      default: w_alu_psw         = w_upd_psw;
    endcase
  end

  // PSW source priority: successful restore, then full load, then ALU/carry ops
  always_comb begin
    w_psw_nxt = w_alu_psw;
    if (w_pop_ok) begin
      w_psw_nxt = psw_fix(w_stk_top);
    end else if (psw_load) begin
      w_psw_nxt = psw_fix(psw_in);
    end else begin
      w_psw_nxt = w_alu_psw;
    end
  end

  // PSW register, updated on the falling edge
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_psw <= psw_fix(RESET_PSW);
    end else begin
      r_psw <= w_psw_nxt;
    end
  end

  // ccc branch condition decoder, purely combinational from the PSW
  always_comb begin
    w_cond = 1'b0;
    case (ccc_e'(cond_sel))
      CC_NZ:   w_cond = ~r_psw[BIT_Z];
      CC_Z:    w_cond =  r_psw[BIT_Z];
      CC_NC:   w_cond = ~r_psw[BIT_CY];
      CC_C:    w_cond =  r_psw[BIT_CY];
      CC_PO:   w_cond = ~r_psw[BIT_P];
      CC_PE:   w_cond =  r_psw[BIT_P];
      CC_P:    w_cond = ~r_psw[BIT_S];
      CC_M:    w_cond =  r_psw[BIT_S];
      default: w_cond = 1'b0;
    endcase
  end

  assign psw_out    = r_psw;
  assign flg_sign   = r_psw[BIT_S];
  assign flg_zero   = r_psw[BIT_Z];
  assign flg_aux    = r_psw[BIT_AC];
  assign flg_parity = r_psw[BIT_P];
  assign flg_carry  = r_psw[BIT_CY];
  assign cond_met   = w_cond;

endmodule

// File: tb/tb_psw_flag_unit.sv
// Self-checking bench for psw_flag_unit: directed scenarios plus a random
// run against a flag-level behavioural model with a queue-based save stack.
module tb_psw_flag_unit;

  localparam int DEPTH = 4;
  localparam int PTR_W = 3;

  logic             clk;
  logic             reset;
  logic             upd_en;
  logic [4:0]       upd_mask;
  logic             is_sign, is_zero, is_aux, is_parity, is_carry;
  logic             psw_load;
  logic [7:0]       psw_in;
  logic [1:0]       cy_op;
  logic             save_req, restore_req;
  logic [2:0]       cond_sel;
  logic [7:0]       psw_out;
  logic             flg_sign, flg_zero, flg_aux, flg_parity, flg_carry;
  logic             cond_met;
  logic [PTR_W-1:0] stk_count;
  logic             stk_full, stk_empty, stk_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: individual flags, a queue as the stack, error bit
  logic       m_s, m_z, m_ac, m_p, m_cy;
  logic [7:0] m_stk [$];
  logic       m_err;

  psw_flag_unit #(.STACK_DEPTH(DEPTH), .RESET_PSW(8'h02)) dut (
    .clk(clk), .reset(reset), .upd_en(upd_en), .upd_mask(upd_mask),
    .is_sign(is_sign), .is_zero(is_zero), .is_aux(is_aux),
    .is_parity(is_parity), .is_carry(is_carry), .psw_load(psw_load),
    .psw_in(psw_in), .cy_op(cy_op), .save_req(save_req),
    .restore_req(restore_req), .cond_sel(cond_sel), .psw_out(psw_out),
    .flg_sign(flg_sign), .flg_zero(flg_zero), .flg_aux(flg_aux),
    .flg_parity(flg_parity), .flg_carry(flg_carry), .cond_met(cond_met),
    .stk_count(stk_count), .stk_full(stk_full), .stk_empty(stk_empty),
    .stk_err(stk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] m_psw();
    return {m_s, m_z, 1'b0, m_ac, 1'b0, m_p, 1'b1, m_cy};
  endfunction

  function automatic logic m_cond(input logic [2:0] sel);
    case (sel)
      3'd0: return !m_z;
      3'd1: return m_z;
      3'd2: return !m_cy;
      3'd3: return m_cy;
      3'd4: return !m_p;
      3'd5: return m_p;
      3'd6: return !m_s;
      default: return m_s;
    endcase
  endfunction

  task automatic m_unpack(input logic [7:0] v);
    m_s = v[7]; m_z = v[6]; m_ac = v[4]; m_p = v[2]; m_cy = v[0];
  endtask

  task automatic m_reset();
    m_unpack(8'h02);
    m_stk.delete();
    m_err = 1'b0;
  endtask

  // Apply one clock edge of architectural behaviour to the model
  task automatic m_step(input logic sv, input logic rs, input logic ld,
                        input logic [7:0] pin, input logic ue,
                        input logic [4:0] mk, input logic [4:0] isv,
                        input logic [1:0] cy);
    logic [7:0] pre;
    logic old_cy;
    pre = m_psw();
    old_cy = m_cy;
    if (rs && m_stk.size() > 0) begin
      if (sv) begin
        m_unpack(m_stk[m_stk.size()-1]);
        m_stk[m_stk.size()-1] = pre;
      end else begin
        m_unpack(m_stk.pop_back());
      end
    end else begin
      if (rs) m_err = 1'b1;
      if (sv) begin
        if (m_stk.size() < DEPTH) m_stk.push_back(pre);
        else m_err = 1'b1;
      end
      if (ld) begin
        m_unpack(pin);
      end else begin
        if (ue) begin
          if (mk[4]) m_s  = isv[4];
          if (mk[3]) m_z  = isv[3];
          if (mk[2]) m_ac = isv[2];
          if (mk[1]) m_p  = isv[1];
          if (mk[0]) m_cy = isv[0];
        end
        if (cy == 2'b01) m_cy = 1'b1;
        else if (cy == 2'b10) m_cy = !old_cy;
      end
    end
  endtask

  task automatic idle_inputs();
    upd_en = 1'b0; upd_mask = 5'd0;
    {is_sign, is_zero, is_aux, is_parity, is_carry} = 5'd0;
    psw_load = 1'b0; psw_in = 8'h00; cy_op = 2'b00;
    save_req = 1'b0; restore_req = 1'b0;
  endtask

  // Drive one cycle between rising edges; outputs settle 1 time unit after the falling edge
  task automatic cycle(input logic sv, input logic rs, input logic ld,
                       input logic [7:0] pin, input logic ue,
                       input logic [4:0] mk, input logic [4:0] isv,
                       input logic [1:0] cy);
    @(posedge clk);
    save_req = sv; restore_req = rs; psw_load = ld; psw_in = pin;
    upd_en = ue; upd_mask = mk;
    {is_sign, is_zero, is_aux, is_parity, is_carry} = isv;
    cy_op = cy;
    @(negedge clk);
    m_step(sv, rs, ld, pin, ue, mk, isv, cy);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    idle_inputs();
    #2 reset = 1'b0;
    m_reset();
    @(posedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 5'd0, 5'd0, 2'b00);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (psw_out !== 8'h02) begin n_errors++; $display("FAIL reset_psw: got %h want 02", psw_out); end
    n_checks++;
    if (stk_empty !== 1'b1 || stk_count !== 3'd0 || stk_err !== 1'b0) begin
      n_errors++; $display("FAIL reset_stack: empty=%b count=%0d err=%b want 1 0 0", stk_empty, stk_count, stk_err);
    end
    m_reset();
    idle_inputs();
    @(posedge clk);
    reset = 1'b1;
  endtask

  task automatic test_masked_update();
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'b01001, 5'b11111, 2'b00);
    n_checks++;
    if (psw_out !== 8'h43) begin n_errors++; $display("FAIL masked_update: got %h want 43", psw_out); end
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'b00000, 5'b00000, 2'b10);
    n_checks++;
    if (psw_out !== 8'h42) begin n_errors++; $display("FAIL cmc: got %h want 42", psw_out); end
    n_checks++;
    if (flg_zero !== 1'b1 || flg_carry !== 1'b0) begin
      n_errors++; $display("FAIL flag_pins: z=%b cy=%b want 1 0", flg_zero, flg_carry);
    end
  endtask

  task automatic test_load_priority();
    cycle(1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 5'b11111, 5'b00000, 2'b00);
    n_checks++;
    if (psw_out !== 8'hD7) begin n_errors++; $display("FAIL load_priority: got %h want d7", psw_out); end
    cond_sel = 3'd7; #1;
    n_checks++;
    if (cond_met !== 1'b1) begin n_errors++; $display("FAIL cond_m: got %b want 1", cond_met); end
    cond_sel = 3'd1; #1;
    n_checks++;
    if (cond_met !== 1'b1) begin n_errors++; $display("FAIL cond_z: got %b want 1", cond_met); end
    cond_sel = 3'd0; #1;
    n_checks++;
    if (cond_met !== 1'b0) begin n_errors++; $display("FAIL cond_nz: got %b want 0", cond_met); end
  endtask

  task automatic test_stack();
    logic [7:0] exp_pop [4];
    exp_pop[0] = 8'hC7; exp_pop[1] = 8'h47; exp_pop[2] = 8'h83; exp_pop[3] = 8'h03;
    cycle(1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 5'd0, 5'd0, 2'b00);
    cycle(1'b1, 1'b0, 1'b1, 8'h83, 1'b0, 5'd0, 5'd0, 2'b00);
    cycle(1'b1, 1'b0, 1'b1, 8'h47, 1'b0, 5'd0, 5'd0, 2'b00);
    cycle(1'b1, 1'b0, 1'b1, 8'hC7, 1'b0, 5'd0, 5'd0, 2'b00);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 5'd0, 2'b00);
    n_checks++;
    if (stk_full !== 1'b1 || stk_count !== 3'd4 || stk_err !== 1'b0) begin
      n_errors++; $display("FAIL stack_full: full=%b count=%0d err=%b want 1 4 0", stk_full, stk_count, stk_err);
    end
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 5'd0, 2'b00);
    n_checks++;
    if (stk_err !== 1'b1 || stk_count !== 3'd4) begin
      n_errors++; $display("FAIL overflow: err=%b count=%0d want 1 4", stk_err, stk_count);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 5'd0, 2'b00);
      n_checks++;
      if (psw_out !== exp_pop[i] || stk_count !== 3'(3 - i)) begin
        n_errors++; $display("FAIL pop_%0d: psw=%h count=%0d want %h %0d", i, psw_out, stk_count, exp_pop[i], 3 - i);
      end
    end
    n_checks++;
    if (stk_empty !== 1'b1 || stk_err !== 1'b1) begin
      n_errors++; $display("FAIL after_pops: empty=%b err=%b want 1 1", stk_empty, stk_err);
    end
  endtask

  task automatic test_swap();
    do_reset();
    cycle(1'b0, 1'b0, 1'b1, 8'h47, 1'b0, 5'd0, 5'd0, 2'b00);
    cycle(1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 5'd0, 5'd0, 2'b00);
    n_checks++;
    if (psw_out !== 8'h02 || stk_count !== 3'd1) begin
      n_errors++; $display("FAIL swap_setup: psw=%h count=%0d want 02 1", psw_out, stk_count);
    end
    cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 5'd0, 2'b00);
    n_checks++;
    if (psw_out !== 8'h47 || stk_count !== 3'd1 || stk_err !== 1'b0) begin
      n_errors++; $display("FAIL swap: psw=%h count=%0d err=%b want 47 1 0", psw_out, stk_count, stk_err);
    end
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 5'd0, 2'b00);
    n_checks++;
    if (psw_out !== 8'h02 || stk_count !== 3'd0) begin
      n_errors++; $display("FAIL swap_top: psw=%h count=%0d want 02 0", psw_out, stk_count);
    end
  endtask

  task automatic test_underflow();
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 5'd0, 2'b01);
    n_checks++;
    if (stk_err !== 1'b1 || psw_out !== 8'h03 || stk_count !== 3'd0) begin
      n_errors++; $display("FAIL underflow: err=%b psw=%h count=%0d want 1 03 0", stk_err, psw_out, stk_count);
    end
    cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 5'd0, 2'b00);
    n_checks++;
    if (stk_count !== 3'd1 || stk_err !== 1'b1 || psw_out !== 8'h03) begin
      n_errors++; $display("FAIL save_restore_empty: count=%0d err=%b psw=%h want 1 1 03", stk_count, stk_err, psw_out);
    end
  endtask

  task automatic test_random();
    logic sv, rs, ld, ue;
    logic [7:0] pin;
    logic [4:0] mk, isv;
    logic [1:0] cy;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      sv  = ($urandom_range(0, 3) == 0);
      rs  = ($urandom_range(0, 3) == 0);
      ld  = ($urandom_range(0, 5) == 0);
      ue  = $urandom_range(0, 1);
      pin = 8'($urandom);
      mk  = 5'($urandom);
      isv = 5'($urandom);
      cy  = 2'($urandom);
      cond_sel = 3'($urandom);
      cycle(sv, rs, ld, pin, ue, mk, isv, cy);
      n_checks++;
      if (psw_out !== m_psw() || stk_count !== 3'(m_stk.size()) || stk_err !== m_err ||
          stk_full !== (m_stk.size() == DEPTH) || stk_empty !== (m_stk.size() == 0) ||
          cond_met !== m_cond(cond_sel)) begin
        n_errors++;
        $display("FAIL random_%0d: psw=%h cnt=%0d err=%b cond=%b want %h %0d %b %b",
                 n, psw_out, stk_count, stk_err, cond_met, m_psw(), m_stk.size(), m_err, m_cond(cond_sel));
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    cond_sel = 3'd0;
    idle_inputs();
    m_reset();
    #12 reset = 1'b1;
    test_reset();
    test_masked_update();
    test_load_priority();
    test_stack();
    test_swap();
    test_underflow();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
